// File: rtl/ucdp_sync_hs_arb.sv
// ---------------------------------------------------------------------------
// ucdp_sync_hs_arb
//
// Source-side controller for one four-phase req/ack CDC channel that is
// shared by NUM_REQ local requesters. A round-robin arbiter picks one
// requester while the channel is idle. It captures that requester's payload
// as bundled data and runs the handshake:
//    req up -> wait ack up -> req down -> wait ack down -> done pulse.
// A per-phase watchdog raises a single pulse when a phase waits longer than
// TIMEOUT cycles. The watchdog never aborts the handshake.
//
// Parameters
//   NUM_REQ  number of requesters (2..16)
//   DWIDTH   payload width per requester
//   TIMEOUT  ack wait limit per phase in cycles, 0 disables the watchdog
//
// Ports
//   src_clk_i   clock
//   src_rst_i   synchronous active-high reset
//   req_i       per-requester request level
//   data_i      payloads, requester k at [k*DWIDTH +: DWIDTH]
//   done_o      one-hot, one-cycle completion pulse
//   grant_o     index of the current or last granted requester
//   busy_o      channel not idle (INIT, REQ or REL)
//   timeout_o   one-cycle pulse when a phase reaches TIMEOUT cycles
//   cdc_req_o   channel request towards the target domain (registered)
//   cdc_data_o  bundled payload, stable while the handshake is in flight
//   cdc_ack_i   channel acknowledge, already synchronised into src_clk_i
// ---------------------------------------------------------------------------
module ucdp_sync_hs_arb #(
   parameter int NUM_REQ = 4,
   parameter int DWIDTH  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                        src_clk_i,
   input  logic                        src_rst_i,
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [NUM_REQ*DWIDTH-1:0]   data_i,
   output logic [NUM_REQ-1:0]          done_o,
   output logic [$clog2(NUM_REQ)-1:0]  grant_o,
   output logic                        busy_o,
   output logic                        timeout_o,
   output logic                        cdc_req_o,
   output logic [DWIDTH-1:0]           cdc_data_o,
   input  logic                        cdc_ack_i
);

   localparam int GW = $clog2(NUM_REQ);
   // A zero-width counter is not legal, so a disabled watchdog keeps one bit.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_REQ  = 2'd2;
   localparam logic [1:0] ST_REL  = 2'd3;

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   logic [1:0]          state_reg,    state_next;
   logic [GW-1:0]       ptr_reg,      ptr_next;
   logic [GW-1:0]       grant_reg,    grant_next;
   logic                cdc_req_reg,  cdc_req_next;
   logic [DWIDTH-1:0]   cdc_data_reg, cdc_data_next;
   logic [NUM_REQ-1:0]  done_reg,     done_next;
   logic                busy_reg,     busy_next;
   logic                timeout_reg,  timeout_next;
   logic [CW-1:0]       cnt_reg,      cnt_next;

   // ------------------------------------------------------------------
   // Payload unpacking and grant decode
   // ------------------------------------------------------------------
   logic [DWIDTH-1:0]   data_arr [NUM_REQ];
   logic [NUM_REQ-1:0]  grant_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign data_arr[gi]     = data_i[gi*DWIDTH +: DWIDTH];
         assign grant_onehot[gi] = (grant_reg == GW'(gi));
      end
   endgenerate

   // ------------------------------------------------------------------
   // Round-robin search
   // The request vector is rotated so that bit 0 is the requester the
   // pointer currently favours. A fixed-priority pick on the rotated
   // vector then yields an offset from the pointer. Doubling the vector
   // makes the rotation a plain index and works for any NUM_REQ, including
   // values that are not a power of two.
   // ------------------------------------------------------------------
   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [GW-1:0]        offset;
   logic [GW:0]          win_sum;
   logic [GW-1:0]        win;
   logic                 found;

   assign req_dbl = {req_i, req_i};

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         assign req_rot[gi] = req_dbl[{1'b0, ptr_reg} + (GW+1)'(gi)];
      end
   endgenerate

   always_comb begin
      found  = |req_rot;
      offset = '0;
      // Descending scan: the lowest set offset is the last one written.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            offset = GW'(i);
         end
      end
   end

   // pointer + offset, reduced modulo NUM_REQ (both operands < NUM_REQ)
   assign win_sum = {1'b0, ptr_reg} + {1'b0, offset};
   assign win     = (win_sum >= (GW+1)'(NUM_REQ)) ?
                    GW'(win_sum - (GW+1)'(NUM_REQ)) : win_sum[GW-1:0];

   // ------------------------------------------------------------------
   // Handshake sequencer
   // ------------------------------------------------------------------
   logic phase_tick;   // waiting for ack inside REQ or REL this cycle

   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      grant_next    = grant_reg;
      cdc_req_next  = cdc_req_reg;
      cdc_data_next = cdc_data_reg;
      done_next     = '0;
      timeout_next  = 1'b0;
      cnt_next      = cnt_reg;
      phase_tick    = 1'b0;

      case (state_reg)
         // Let a handshake left over from before reset finish on the
         // remote side. An ack that is high here is simply waited out.
         ST_INIT: begin
            if (!cdc_ack_i) begin
               state_next = ST_IDLE;
            end
         end

         // A stray ack rise here is a protocol error and is ignored.
         ST_IDLE: begin
            if (found) begin
               state_next    = ST_REQ;
               grant_next    = win;
               cdc_data_next = data_arr[win];
               cdc_req_next  = 1'b1;
               ptr_next      = (win == GW'(NUM_REQ - 1)) ? '0 : win + GW'(1);
               cnt_next      = '0;
            end
         end

         ST_REQ: begin
            if (cdc_ack_i) begin
               state_next   = ST_REL;
               cdc_req_next = 1'b0;
               cnt_next     = '0;
            end else begin
               phase_tick = 1'b1;
            end
         end

         ST_REL: begin
            if (!cdc_ack_i) begin
               state_next = ST_IDLE;
               done_next  = grant_onehot;
            end else begin
               phase_tick = 1'b1;
            end
         end

         default: begin
            state_next   = ST_INIT;
            cdc_req_next = 1'b0;
         end
      endcase

      // Watchdog: count only while staying in a waiting phase. The counter
      // saturates at TIMEOUT, so the match on TIMEOUT-1 fires once per phase.
      if (phase_tick) begin
         if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CW'(1);
         end
         timeout_next = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);
      end
   end

   assign busy_next = (state_next != ST_IDLE);

   always_ff @(posedge src_clk_i) begin
      if (src_rst_i) begin
         state_reg    <= ST_INIT;
         ptr_reg      <= '0;
         grant_reg    <= '0;
         cdc_req_reg  <= 1'b0;
         cdc_data_reg <= '0;
         done_reg     <= '0;
         busy_reg     <= 1'b1;
         timeout_reg  <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         grant_reg    <= grant_next;
         cdc_req_reg  <= cdc_req_next;
         cdc_data_reg <= cdc_data_next;
         done_reg     <= done_next;
         busy_reg     <= busy_next;
         timeout_reg  <= timeout_next;
         cnt_reg      <= cnt_next;
      end
   end

   assign done_o     = done_reg;
   assign grant_o    = grant_reg;
   assign busy_o     = busy_reg;
   assign timeout_o  = timeout_reg;
   assign cdc_req_o  = cdc_req_reg;
   assign cdc_data_o = cdc_data_reg;

endmodule

// File: tb/tb_ucdp_sync_hs_arb.sv
// ---------------------------------------------------------------------------
// tb_ucdp_sync_hs_arb
//
// Bench for ucdp_sync_hs_arb with NUM_REQ=4, DWIDTH=8, TIMEOUT=10. A second
// instance with TIMEOUT=0 shares all inputs and must never raise timeout_o.
// The remote side is modelled as a 2-flop req sync plus a 2-flop ack sync,
// so ack follows cdc_req_o four cycles later unless the test overrides it.
// Expected grants are queued when requests are driven and popped by a
// monitor when cdc_req_o rises.
// ---------------------------------------------------------------------------
module tb_ucdp_sync_hs_arb;

   logic        clk = 1'b0;
   logic        srst;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  done;
   logic [1:0]  grant;
   logic        busy;
   logic        timeout;
   logic        cdc_req;
   logic [7:0]  cdc_data;
   logic        cdc_ack;

   logic [3:0]  done_z;
   logic [1:0]  grant_z;
   logic        busy_z;
   logic        timeout_z;
   logic        cdc_req_z;
   logic [7:0]  cdc_data_z;

   ucdp_sync_hs_arb #(.NUM_REQ(4), .DWIDTH(8), .TIMEOUT(10)) dut (
      .src_clk_i (clk),
      .src_rst_i (srst),
      .req_i     (req),
      .data_i    (data),
      .done_o    (done),
      .grant_o   (grant),
      .busy_o    (busy),
      .timeout_o (timeout),
      .cdc_req_o (cdc_req),
      .cdc_data_o(cdc_data),
      .cdc_ack_i (cdc_ack)
   );

   ucdp_sync_hs_arb #(.NUM_REQ(4), .DWIDTH(8), .TIMEOUT(0)) dut_noto (
      .src_clk_i (clk),
      .src_rst_i (srst),
      .req_i     (req),
      .data_i    (data),
      .done_o    (done_z),
      .grant_o   (grant_z),
      .busy_o    (busy_z),
      .timeout_o (timeout_z),
      .cdc_req_o (cdc_req_z),
      .cdc_data_o(cdc_data_z),
      .cdc_ack_i (cdc_ack)
   );

   always #5 clk = ~clk;

   // remote domain: req through 2 flops, ack back through 2 flops
   logic [3:0] ack_pipe = '0;
   logic       ack_force;
   logic       ack_val;
   always @(posedge clk) ack_pipe <= {ack_pipe[2:0], cdc_req};
   assign cdc_ack = ack_force ? ack_val : ack_pipe[3];

   typedef struct packed {
      logic [1:0] grant;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [1:0]  grant;
      logic [7:0]  exp_data;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        tbl[7];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          rise_cyc = -1;
   int          to10_cnt = 0;
   int          to10_cyc = -1;
   int          to0_cnt  = 0;
   int          done_cnt[4] = '{0, 0, 0, 0};
   logic [1:0]  cur_grant = 2'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Samples 1 time unit after every rising edge.
   task automatic monitor();
      logic       prev_req;
      logic [7:0] prev_data;
      exp_t       e;
      prev_req  = 1'b0;
      prev_data = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (srst) begin
            prev_req  = cdc_req;
            prev_data = cdc_data;
            continue;
         end
         if (cdc_req && !prev_req) begin
            rise_cyc = cyc;
            chk("grant_busy", busy, 1);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_grant: grant %0d data %0h with nothing expected", grant, cdc_data);
            end else begin
               e = exp_q.pop_front();
               chk("grant", grant, e.grant);
               chk("grant_data", cdc_data, e.data);
               cur_grant = e.grant;
               $display("grant %0d data %0h at cycle %0d", grant, cdc_data, cyc);
            end
         end else begin
            chk("data_stable", cdc_data, prev_data);
         end
         if (done != 0) begin
            chk("done_onehot", done, 4'b0001 << cur_grant);
            done_cnt[cur_grant]++;
            $display("done %b at cycle %0d", done, cyc);
         end
         if (timeout) begin
            to10_cnt++;
            to10_cyc = cyc;
         end
         if (timeout_z) to0_cnt++;
         prev_req  = cdc_req;
         prev_data = cdc_data;
      end
   endtask

   task automatic wait_rise(input string name);
      int n = 0;
      while (!cdc_req && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk(name, cdc_req, 1);
   endtask

   task automatic wait_done(output logic [3:0] d);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done == 0 && n < 80);
      d = done;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0]  d;
      logic [1:0]  g;
      int          n;
      int          cycles;
      int          low;
      int          base[4];
      int          base10;
      int          base0;

      tbl[0] = '{4'b0011, 32'h44332211, 2'd0, 8'h11};
      tbl[1] = '{4'b1001, 32'hD4C3B2A1, 2'd3, 8'hD4};
      tbl[2] = '{4'b0110, 32'h0F1E2D3C, 2'd1, 8'h2D};
      tbl[3] = '{4'b0011, 32'h55AA6699, 2'd0, 8'h99};
      tbl[4] = '{4'b1000, 32'h8001FF7E, 2'd3, 8'h80};
      tbl[5] = '{4'b0101, 32'h13579BDF, 2'd0, 8'hDF};
      tbl[6] = '{4'b1110, 32'hCAFEBABE, 2'd1, 8'hBA};

      srst      = 1'b1;
      req       = '0;
      data      = '0;
      ack_force = 1'b1;
      ack_val   = 1'b1;
      fork
         monitor();
      join_none

      // ---- reset with ack held high, then INIT -> IDLE -> first grant
      repeat (2) @(negedge clk);
      chk("rst_cdc_req", cdc_req, 0);
      chk("rst_cdc_data", cdc_data, 0);
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_busy", busy, 1);
      req  = 4'b0001;
      data = 32'h44332211;
      exp_q.push_back('{2'd0, 8'h11});
      srst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("init_busy", busy, 1);
         chk("init_no_req", cdc_req, 0);
      end
      ack_force = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_no_req", cdc_req, 0);
      @(negedge clk);
      chk("first_grant_req", cdc_req, 1);
      req = '0;
      wait_done(d);
      chk("first_done", d, 4'b0001);

      // ---- single request, ptr=1 -> requester 2
      @(negedge clk);
      req  = 4'b0100;
      data = 32'h5AA51234;
      exp_q.push_back('{2'd2, 8'hA5});
      wait_rise("single_rise");
      n = 0;
      while (cdc_req && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("single_req_len", n, 5);
      wait_done(d);
      req = '0;
      chk("single_done", d, 4'b0100);
      chk("single_data", cdc_data, 8'hA5);
      chk("single_busy", busy, 0);
      @(negedge clk);
      chk("single_done_pulse", done, 0);

      // ---- table: round-robin picks, req dropped after grant, data churn
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         req  = tbl[i].req;
         data = tbl[i].data;
         exp_q.push_back('{tbl[i].grant, tbl[i].exp_data});
         wait_rise("tbl_rise");
         req = '0;
         n = 0;
         while (done == 0 && n < 40) begin
            data = $urandom;
            @(negedge clk);
            n++;
         end
         chk("tbl_done", done, 4'b0001 << tbl[i].grant);
         chk("tbl_grant", grant, tbl[i].grant);
         chk("tbl_data", cdc_data, tbl[i].exp_data);
         @(negedge clk);
         chk("tbl_idle", busy, 0);
      end

      // ---- reset, then all four requesting: 8 transactions 0,1,2,3,0,1,2,3
      @(negedge clk);
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      for (int j = 0; j < 4; j++) base[j] = done_cnt[j];
      data = 32'hD3C2B1A0;
      for (int k = 0; k < 8; k++) begin
         g = 2'(k % 4);
         exp_q.push_back('{g, data[(k % 4) * 8 +: 8]});
      end
      req    = 4'b1111;
      n      = 0;
      cycles = 0;
      while (n < 8 && cycles < 300) begin
         @(negedge clk);
         cycles++;
         if (done != 0) n++;
      end
      req = '0;
      chk("cont_done_total", n, 8);
      for (int j = 0; j < 4; j++) chk("cont_done_per_req", done_cnt[j] - base[j], 2);
      repeat (15) @(negedge clk);
      chk("cont_queue_empty", exp_q.size(), 0);
      chk("cont_idle", busy, 0);

      // ---- ack withheld 30 cycles: one timeout pulse 10 cycles after REQ entry
      @(negedge clk);
      req    = 4'b0010;
      data   = 32'h01234567;
      base10 = to10_cnt;
      base0  = to0_cnt;
      exp_q.push_back('{2'd1, 8'h45});
      wait_rise("to_rise");
      ack_force = 1'b1;
      ack_val   = 1'b0;
      low = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!cdc_req) low++;
      end
      chk("to_req_held", low, 0);
      chk("to_pulse_count", to10_cnt - base10, 1);
      chk("to_pulse_time", to10_cyc - rise_cyc, 10);
      ack_force = 1'b0;
      wait_done(d);
      req = '0;
      chk("to_done", d, 4'b0010);
      chk("to_pulse_after", to10_cnt - base10, 1);
      chk("to_disabled_none", to0_cnt - base0, 0);

      // ---- reset in REQ with ack high; re-grant from pointer 0
      @(negedge clk);
      req  = 4'b1100;
      data = 32'h9ABCDEF0;
      exp_q.push_back('{2'd2, 8'hBC});
      wait_rise("mid_rise");
      srst      = 1'b1;
      ack_force = 1'b1;
      ack_val   = 1'b1;
      exp_q.push_back('{2'd2, 8'hBC});
      @(negedge clk);
      chk("mid_rst_req", cdc_req, 0);
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_data", cdc_data, 0);
      srst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_init_busy", busy, 1);
         chk("mid_init_no_req", cdc_req, 0);
      end
      ack_force = 1'b0;
      wait_rise("mid_regrant_rise");
      chk("mid_regrant", grant, 2);
      req = '0;
      wait_done(d);
      chk("mid_done", d, 4'b0100);

      repeat (5) @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_to10_total", to10_cnt, 1);
      chk("final_to0_total", to0_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ucdp_sync_hs_arb.md
# ucdp_sync_hs_arb

Source-domain controller that shares one four-phase request/acknowledge CDC channel between `NUM_REQ` local requesters. It round-robin arbitrates, registers the winner's payload as bundled data, and drives the channel request line, which the target domain samples through a two-flop sync leaf. It sequences the handshake against the acknowledge, which comes back through a sync leaf into this domain. It also flags handshakes that stall longer than a configurable timeout.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DWIDTH`, 8: payload width per requester, >= 1.
- `TIMEOUT`, 255: ack wait limit in cycles per handshake phase; 0 disables; max 65535.
- `src_clk_i` in 1: clock. One clock; reset is synchronous and active-high.
- `src_rst_i` in 1: synchronous reset, active-high.
- `req_i` in `NUM_REQ`: per-requester request level.
- `data_i` in `NUM_REQ*DWIDTH`: payloads; requester k occupies bits `[k*DWIDTH +: DWIDTH]`.
- `done_o` out `NUM_REQ`: one-hot, one-cycle completion pulse.
- `grant_o` out `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `busy_o` out 1: channel not idle.
- `timeout_o` out 1: one-cycle pulse when a phase exceeds `TIMEOUT`.
- `cdc_req_o` out 1: channel request; goes to the target domain; registered, glitch-free.
- `cdc_data_o` out `DWIDTH`: bundled payload; registered and stable while `cdc_req_o`=1 and during release.
- `cdc_ack_i` in 1: channel acknowledge, already synchronized into `src_clk_i`; its value after reset is unknown.

## Operation
- FSM states:
  - INIT: wait for `cdc_ack_i`=0, then go to IDLE.
  - IDLE: if any `req_i` bit is set, grant and go to REQ.
  - REQ: hold `cdc_req_o`=1 until `cdc_ack_i`=1, then go to REL.
  - REL: hold `cdc_req_o`=0 until `cdc_ack_i`=0, then go to IDLE with a `done_o` pulse.
- Arbitration happens only in IDLE:
  - Round-robin with pointer p. The search starts at p and wraps modulo `NUM_REQ`.
  - Winner k: `grant_o`<=k, `cdc_data_o`<=`data_i[k]`, `cdc_req_o`<=1, p<=(k+1) mod `NUM_REQ`.
  - p resets to 0.
- `req_i` is a level. A requester keeps it high until its `done_o` pulse.
  - If `req_i[k]` is still high in the cycle after `done_o[k]`, that is a new request, ranked by the round-robin order.
  - Dropping `req_i[k]` after grant has no effect. The in-flight handshake completes and `done_o[k]` still pulses.
- `data_i` is sampled only at grant. Later changes do not affect `cdc_data_o`.
- Timeout counter:
  - Width `$clog2(TIMEOUT+1)`. Cleared on entry to REQ and to REL; increments each cycle in those states.
  - `timeout_o` pulses once, in the cycle the count reaches `TIMEOUT`, then the counter saturates.
  - The FSM never aborts a handshake on timeout; it keeps waiting.
  - One pulse at most per phase, so at most two per transaction.
  - INIT has no timeout.
- `busy_o`=1 in INIT, REQ and REL; 0 in IDLE.
- Reset values: `cdc_req_o`=0, `cdc_data_o`=0, `grant_o`=0, `done_o`=0, `timeout_o`=0, `busy_o`=1, state INIT.
- Reset mid-handshake: the next edge forces all of the above values. INIT then drains any half-finished remote handshake before the next grant.
- `cdc_ack_i` rising in IDLE or INIT is a protocol error. It is ignored; no state change.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Grant latency: `req_i` high sampled in IDLE at edge t → `cdc_req_o`, `cdc_data_o`, `grant_o` and `busy_o`=1 valid after edge t.
- `cdc_ack_i`=1 sampled at edge a → `cdc_req_o`=0 after edge a.
- `cdc_ack_i`=0 sampled at edge b → after edge b: `done_o[k]`=1 for one cycle, `busy_o`=0, state IDLE.
- Earliest next `cdc_req_o` rise: after edge b+1. A single requester therefore gets at most one transaction per (4 + round-trip) cycles.
- `cdc_data_o` changes only at the grant edge. It is never changed while `cdc_req_o`=1 or in REL.
- Simultaneous grant and `done_o` in the same cycle cannot occur.

## Test plan
- Reset with `cdc_ack_i`=1 held 5 cycles, then 0: `busy_o`=1 and `cdc_req_o`=0 throughout; IDLE reached one cycle after ack low; no grant before that.
- Single request: `req_i`=4'b0100, `data_i[2]`=8'hA5, ack model 2-cycle sync each way → `grant_o`=2, `cdc_data_o`=8'hA5 stable through REQ/REL, one `done_o`=4'b0100 pulse, `cdc_req_o` high for exactly req-to-ack latency.
- All four requesting continuously, 8 transactions: grant order 0,1,2,3,0,1,2,3; each requester gets exactly 2 `done_o` pulses.
- `data_i[0]` changes every cycle after grant: `cdc_data_o` keeps the grant-cycle value until the next grant.
- `TIMEOUT`=10, ack withheld 30 cycles: `timeout_o` pulses exactly once, 10 cycles after the REQ entry edge; `cdc_req_o` remains 1; handshake completes normally once ack arrives. With `TIMEOUT`=0: no pulse.
- `src_rst_i` asserted in REQ with ack=1: `cdc_req_o`=0 next edge; FSM in INIT until ack falls; the pending requester is re-granted afterwards with p=0.
